// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester latch-memory arbiter:
// sequencer states, default memory geometry and requester indices.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_ADDR_W = 2;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WPULSE,
        HOLD,
        RSAMPLE,
        DONE
    } state_t;

    // One-hot grant vector for a requester index (bit 0 = requester 0).
    function automatic logic [1:0] onehot_of(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Holds the last contended winner; when both
// requests are high the other requester wins. A lone request always wins
// and leaves the history untouched.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    logic r_last_gnt;
    logic w_winner;

    // Pick the winner from the current requests and the contention history.
    always_comb begin
        w_winner = 1'b0;
        o_gnt    = 2'b00;
        if (i_req[REQ0] && i_req[REQ1]) begin
            w_winner = ~r_last_gnt;
        end else begin
            w_winner = i_req[REQ1];
        end
        if (i_req != 2'b00) begin
            o_gnt = onehot_of(w_winner);
        end
    end

    // Remember the winner of each contended grant; requester 0 wins first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (i_update && (&i_req)) begin
            r_last_gnt <= w_winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and latch-safe sequencer for a small D/SEL/E/Q latch memory.
// Address and data are registered one cycle before E rises, E is held for
// WE_CYCLES cycles, and address/data stay stable one cycle after E falls.
// Optional build macro MEM_ARB_RDBACK_EN adds a read-back verify after each
// write and drives a sticky ERR flag on mismatch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WE_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              R0_REQ,
    input  logic              R0_WE,
    input  logic [ADDR_W-1:0] R0_ADDR,
    input  logic [DATA_W-1:0] R0_WDATA,
    output logic              R0_ACK,
    output logic [DATA_W-1:0] R0_RDATA,
    input  logic              R1_REQ,
    input  logic              R1_WE,
    input  logic [ADDR_W-1:0] R1_ADDR,
    input  logic [DATA_W-1:0] R1_WDATA,
    output logic              R1_ACK,
    output logic [DATA_W-1:0] R1_RDATA,
    output logic [DATA_W-1:0] MEM_D,
    output logic [ADDR_W-1:0] MEM_SEL,
    output logic              MEM_E,
    input  logic [DATA_W-1:0] MEM_Q,
    output logic              ERR
);

    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        w_gnt;
    logic              w_start;
    logic              w_pulse_last;
    logic              r_we;
    logic              r_win;
    logic [ADDR_W-1:0] r_mem_sel;
    logic [DATA_W-1:0] r_mem_d;
    logic              r_mem_e;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    rr_arb2 u_arb (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_req    ({R1_REQ, R0_REQ}),
        .i_update (r_state == IDLE),
        .o_gnt    (w_gnt)
    );

    assign w_start      = (r_state == IDLE) && (|w_gnt);
    assign w_pulse_last = (r_cnt == CNT_W'(WE_CYCLES - 1));

    // Sequencer next-state: setup, E pulse, hold (optional verify), ack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = SETUP;
            SETUP:   w_state_next = r_we ? WPULSE : RSAMPLE;
            WPULSE:  if (w_pulse_last) w_state_next = HOLD;
`ifdef MEM_ARB_RDBACK_EN
            HOLD:    w_state_next = RSAMPLE;
`else
            HOLD:    w_state_next = DONE;
`endif
            RSAMPLE: w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command capture, registered memory strobes, acks and read data.
    // SEL/D only load on the IDLE->SETUP edge, where E is guaranteed low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_we      <= 1'b0;
            r_win     <= 1'b0;
            r_mem_sel <= '0;
            r_mem_d   <= '0;
            r_mem_e   <= 1'b0;
            r_cnt     <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            if (w_start) begin
                if (w_gnt[REQ1]) begin
                    r_win     <= 1'b1;
                    r_we      <= R1_WE;
                    r_mem_sel <= R1_ADDR;
                    r_mem_d   <= R1_WDATA;
                end else begin
                    r_win     <= 1'b0;
                    r_we      <= R0_WE;
                    r_mem_sel <= R0_ADDR;
                    r_mem_d   <= R0_WDATA;
                end
            end
            r_mem_e <= (w_state_next == WPULSE);
            r_cnt   <= (r_state == WPULSE) ? r_cnt + CNT_W'(1) : '0;
            r_ack0  <= (w_state_next == DONE) && !r_win;
            r_ack1  <= (w_state_next == DONE) && r_win;
            if ((r_state == RSAMPLE) && !r_we) begin
                if (r_win) r_rdata1 <= MEM_Q;
                else       r_rdata0 <= MEM_Q;
            end
        end
    end

`ifdef MEM_ARB_RDBACK_EN
    logic r_err;

    // Sticky flag: the word read back after a write differs from what was written.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err <= 1'b0;
        end else if ((r_state == RSAMPLE) && r_we && (MEM_Q != r_mem_d)) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    assign MEM_SEL  = r_mem_sel;
    assign MEM_D    = r_mem_d;
    assign MEM_E    = r_mem_e;
    assign R0_ACK   = r_ack0;
    assign R1_ACK   = r_ack1;
    assign R0_RDATA = r_rdata0;
    assign R1_RDATA = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latch memory model, a
// transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

`ifdef MEM_ARB_RDBACK_EN
    localparam int TB_WE = 2;
    localparam int TB_RB = 1;
`else
    localparam int TB_WE = 1;
    localparam int TB_RB = 0;
`endif
    localparam int WR_LEN = 3 + TB_WE + TB_RB;
    localparam int RD_LEN = 3;

    logic       CLK;
    logic       RST_N;
    logic       R0_REQ, R0_WE, R1_REQ, R1_WE;
    logic [1:0] R0_ADDR, R1_ADDR;
    logic [2:0] R0_WDATA, R1_WDATA;
    logic       R0_ACK, R1_ACK;
    logic [2:0] R0_RDATA, R1_RDATA;
    logic [2:0] MEM_D;
    logic [1:0] MEM_SEL;
    logic       MEM_E;
    logic [2:0] MEM_Q;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    // latch memory (written while E is high) and read-back fault injection
    bit   [2:0] lmem [4];
    logic [2:0] q_flip = 3'b000;

    mem_arbiter #(.DATA_W(3), .ADDR_W(2), .WE_CYCLES(TB_WE)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
        .R0_ACK(R0_ACK), .R0_RDATA(R0_RDATA),
        .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
        .R1_ACK(R1_ACK), .R1_RDATA(R1_RDATA),
        .MEM_D(MEM_D), .MEM_SEL(MEM_SEL), .MEM_E(MEM_E), .MEM_Q(MEM_Q), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) if (MEM_E) lmem[MEM_SEL] <= MEM_D;
    assign MEM_Q = lmem[MEM_SEL] ^ q_flip;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int       m_phase;            // 0 idle, 1..m_len cycle within a transaction
    int       m_len;
    bit       m_last, m_win, m_we;
    bit [2:0] m_d, m_flip, m_rd0, m_rd1;
    bit [1:0] m_sel;
    bit       m_err;
    bit [2:0] mem_m [4];

    task automatic model_reset();
        m_phase = 0; m_len = RD_LEN; m_last = 1'b1; m_win = 1'b0; m_we = 1'b0;
        m_d = 0; m_sel = 0; m_flip = 0; m_rd0 = 0; m_rd1 = 0; m_err = 1'b0;
    endtask

    task automatic model_step();
        if (m_phase != 0) begin
            if (m_phase == m_len) m_phase = 0;
            else begin
                m_phase++;
                if (m_phase == m_len) begin
                    if (!m_we) begin
                        if (m_win) m_rd1 = mem_m[m_sel]; else m_rd0 = mem_m[m_sel];
                    end else if (TB_RB == 1 && m_flip != 0) m_err = 1'b1;
                end
            end
        end else if (R0_REQ || R1_REQ) begin
            if (R0_REQ && R1_REQ) begin
                m_win  = !m_last;
                m_last = m_win;
            end else m_win = R1_REQ;
            m_we    = m_win ? R1_WE : R0_WE;
            m_sel   = m_win ? R1_ADDR : R0_ADDR;
            m_d     = m_win ? R1_WDATA : R0_WDATA;
            m_flip  = q_flip;
            m_len   = m_we ? WR_LEN : RD_LEN;
            m_phase = 1;
            if (m_we) mem_m[m_sel] = m_d;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset(); else model_step();
        end
    end

    // Compare every cycle against the model while out of reset.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                chk("mem_e", MEM_E, (m_we && m_phase >= 2 && m_phase <= 1 + TB_WE) ? 1 : 0);
                chk("mem_sel", MEM_SEL, m_sel);
                chk("mem_d", MEM_D, m_d);
                chk("r0_ack", R0_ACK, (m_phase != 0 && m_phase == m_len && !m_win) ? 1 : 0);
                chk("r1_ack", R1_ACK, (m_phase != 0 && m_phase == m_len && m_win) ? 1 : 0);
                chk("r0_rdata", R0_RDATA, m_rd0);
                chk("r1_rdata", R1_RDATA, m_rd1);
                chk("err", ERR, m_err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int idx, input bit req, input bit we, input bit [1:0] a, input bit [2:0] d);
        if (idx == 0) begin R0_REQ = req; R0_WE = we; R0_ADDR = a; R0_WDATA = d; end
        else          begin R1_REQ = req; R1_WE = we; R1_ADDR = a; R1_WDATA = d; end
    endtask

    // Single transaction from an idle arbiter; request dropped one cycle after grant.
    task automatic single(input int idx, input bit we, input bit [1:0] a, input bit [2:0] d,
                          input bit scramble, output int lat);
        bit got = 1'b0;
        @(negedge CLK);
        drive(idx, 1'b1, we, a, d);
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (i == 0) drive(idx, 1'b0, we, scramble ? 2'd0 : a, scramble ? 3'd0 : d);
            if ((idx == 0) ? R0_ACK : R1_ACK) got = 1'b1;
        end
        if (!got) chk("ack_timeout", 0, 1);
        $display("txn req%0d we=%0d addr=%0d data=%0d latency=%0d", idx, we, a, d, lat);
        @(negedge CLK);
    endtask

    int lat;
    int acks [$];
    bit [2:0] w0;
    bit seen_e;

    initial begin
        RST_N = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        chk("rst_mem_e", MEM_E, 0);
        chk("rst_sel", MEM_SEL, 0);
        chk("rst_d", MEM_D, 0);
        chk("rst_acks", {R0_ACK, R1_ACK}, 0);
        chk("rst_rdata", {R0_RDATA, R1_RDATA}, 0);
        chk("rst_err", ERR, 0);
        #2 RST_N = 1'b1;

        // write 5 to word 2, then read it back from requester 1
        single(0, 1, 2, 5, 0, lat);
        chk("wr_latency", lat, WR_LEN);
        chk("mem2", lmem[2], 5);
        single(1, 0, 2, 0, 0, lat);
        chk("rd_latency", lat, 3);
        chk("r1_rdata_lit", R1_RDATA, 5);
        chk("r0_rdata_lit", R0_RDATA, 0);

        // command captured at grant; address and request change afterwards
        w0 = lmem[0];
        single(0, 1, 1, 3, 1, lat);
        chk("cap_latency", lat, WR_LEN);
        chk("mem1", lmem[1], 3);
        chk("mem0_untouched", lmem[0], w0);

        // reset while E is high
        @(negedge CLK);
        drive(0, 1, 1, 0, 7);
        seen_e = 1'b0;
        for (int i = 0; i < 10 && !seen_e; i++) begin
            @(negedge CLK);
            if (MEM_E) seen_e = 1'b1;
        end
        chk("saw_wpulse", seen_e, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_async_e", MEM_E, 0);
        chk("rst_async_ack", {R0_ACK, R1_ACK}, 0);
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        single(0, 1, 0, 4, 0, lat);
        chk("post_rst_latency", lat, WR_LEN);
        chk("mem0_after", lmem[0], 4);

        // contention held continuously: grants must alternate R0, R1, R0, R1
        @(negedge CLK);
        drive(0, 1, 1, 3, 6);
        drive(1, 1, 0, 3, 0);
        for (int i = 0; i < 60 && acks.size() < 4; i++) begin
            @(negedge CLK);
            if (R0_ACK) acks.push_back(0);
            if (R1_ACK) acks.push_back(1);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("rr_count", acks.size(), 4);
        for (int i = 0; i < acks.size() && i < 4; i++) begin
            chk("rr_order", acks[i], i % 2);
            $display("contention ack %0d from req%0d", i, acks[i]);
        end
        chk("rr_rdata", R1_RDATA, 6);
        repeat (3) @(negedge CLK);

`ifdef MEM_ARB_RDBACK_EN
        single(0, 1, 3, 2, 0, lat);
        chk("rb_clean_err", ERR, 0);
        q_flip = 3'b001;
        single(0, 1, 3, 5, 0, lat);
        q_flip = 3'b000;
        chk("rb_latency", lat, 6);
        chk("rb_err_set", ERR, 1);
        repeat (4) @(negedge CLK);
        chk("rb_err_sticky", ERR, 1);
`endif

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            drive(0, ($urandom % 3) == 0, $urandom % 2, 2'($urandom), 3'($urandom));
            drive(1, ($urandom % 3) == 0, $urandom % 2, 2'($urandom), 3'($urandom));
            if (R0_ACK || R1_ACK)
                $display("rand ack r0=%0d r1=%0d rd0=%0d rd1=%0d", R0_ACK, R1_ACK, R0_RDATA, R1_RDATA);
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (10) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 4-word x 3-bit latch memory (D/SEL/E/Q port).
- Captures each requester's command and applies round-robin arbitration.
- Generates latch-safe timing for the memory: address/data set up before E rises, E pulse, hold after E falls. Reads are sampled from Q.
- Sits between the memory and any two clocked masters; all timing to the memory is synchronous to CLK.

Parameters:
- DATA_W, 3, memory word width.
- ADDR_W, 2, memory address width (2^ADDR_W words).
- WE_CYCLES, 1, number of cycles MEM_E is held high per write (>=1).

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- R0_REQ  input  1  requester 0 command request.
- R0_WE  input  1  requester 0: 1 = write, 0 = read.
- R0_ADDR  input  ADDR_W  requester 0 word address.
- R0_WDATA  input  DATA_W  requester 0 write data.
- R0_ACK  output  1  one-cycle completion pulse to requester 0.
- R0_RDATA  output  DATA_W  read data for requester 0.
- R1_REQ, R1_WE, R1_ADDR, R1_WDATA, R1_ACK, R1_RDATA: same as the R0_* ports, for requester 1.
- MEM_D  output  DATA_W  memory data in.
- MEM_SEL  output  ADDR_W  memory word select.
- MEM_E  output  1  memory write enable (level, latch-transparent when high).
- MEM_Q  input  DATA_W  memory read data (combinational from MEM_SEL).
- ERR  output  1  sticky write-verify error (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (async, RST_N=0):
  - State is IDLE.
  - MEM_E=0, MEM_SEL=0, MEM_D=0.
  - R0_ACK=R1_ACK=0, R0_RDATA=R1_RDATA=0, ERR=0.
  - LAST_GNT=1, so requester 0 wins the first contention.
- FSM states: IDLE, SETUP, WPULSE, HOLD, RSAMPLE, DONE.
- IDLE:
  - If any REQ is high, grant and capture WE/ADDR/WDATA of the winner into internal registers, then go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration:
  - One REQ high: that requester wins.
  - Both high: the requester != LAST_GNT wins, and LAST_GNT is updated to the winner.
  - Arbitration happens only in IDLE; no preemption.
- SETUP:
  - MEM_SEL=captured addr, MEM_D=captured data, MEM_E=0.
  - Next state is WPULSE if write, RSAMPLE if read.
- WPULSE:
  - MEM_E=1 for exactly WE_CYCLES cycles; MEM_SEL/MEM_D stable.
  - Next state is HOLD.
- HOLD: MEM_E=0, MEM_SEL/MEM_D still stable for 1 cycle; next state is DONE.
- RSAMPLE: MEM_E=0; on exit, register MEM_Q into the winner's RDATA; next state is DONE.
- DONE:
  - Winner's ACK=1 for exactly this cycle.
  - Next state is IDLE; a new arbitration occurs in IDLE (one idle cycle between transactions).
- Latency, with REQ seen in IDLE at edge t:
  - Write ACK is high in cycle t+3+WE_CYCLES (t+4 at default).
  - Read ACK is high in cycle t+3.
- RDATA: valid in the ACK cycle; holds until that requester's next read completes. Writes do not alter RDATA.
- Command capture:
  - Command is captured at grant; the requester may change or drop ADDR/WDATA/REQ after grant.
  - The transaction still completes and ACK still pulses.
- REQ still high in the ACK cycle counts as a new request in the following IDLE.
- MEM_E is never high in the same cycle MEM_SEL or MEM_D changes (glitch-free latch write). All memory outputs are registered.
- Reset mid-WPULSE: MEM_E drops asynchronously. The targeted word holds either the old or the new value (either accepted); other words are unaffected.
- Address wrap: none needed; ADDR_W bits cover all words.

Optional Feature:
- MEM_ARB_RDBACK_EN defined:
  - After HOLD on a write, enter RSAMPLE (MEM_E=0), compare MEM_Q against the captured data.
  - On mismatch, set ERR=1 (sticky until reset).
  - Write latency becomes t+4+WE_CYCLES.
  - RDATA is not updated by the readback.
- MEM_ARB_RDBACK_EN undefined: no readback state for writes, ERR tied 0, latencies as above.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, SETUP, WPULSE, HOLD, RSAMPLE, DONE);
  - default DATA_W/ADDR_W constants;
  - requester index constants REQ0=0, REQ1=1.
- One sub-module: rr_arb2, the 2-way round-robin arbiter. It holds LAST_GNT; inputs are the two REQs and an update strobe; output is a one-hot grant.
- WE_CYCLES counter and FSM stay in mem_arbiter.

Test Plan:
- R0 write addr=2 data=5, R1 idle -> MEM_SEL=2/MEM_D=5 one cycle before MEM_E=1 for 1 cycle, stable 1 cycle after; R0_ACK at t+4; memory word 2 = 5.
- R1 read addr=2 after the above -> R1_ACK at t+3 with R1_RDATA=5; R0_RDATA unchanged (0).
- R0 and R1 both raise REQ in the same cycle, held continuously -> grants alternate R0, R1, R0, R1; exactly one ACK per transaction, never both ACKs in the same cycle.
- R0 requests write addr=1 data=3, then changes ADDR to 0 and drops REQ one cycle after grant -> word 1 = 3, word 0 untouched, R0_ACK still pulses once.
- RST_N low during WPULSE -> MEM_E=0 and ACKs 0 immediately; after release, FSM in IDLE and a fresh R0 write completes normally.
- With MEM_ARB_RDBACK_EN defined and WE_CYCLES=2, force MEM_Q mismatch on the write to addr=3 -> ERR=1 and stays 1; ACK at t+6; without a mismatch ERR stays 0.
